eth_rx_mii_framer: RTL
======================

// Module: eth_rx_mii_framer
// PURPOSE
//  MII receive-side framer for the Ethernet MAC; counterpart of the TX MAC path (MTxD/MTxEn/MTxErr).
//  Strips preamble/SFD from MRxD nibbles, assembles bytes low-nibble-first, streams them out with
//  SOF/valid strobes, checks FCS (CRC-32), frame length, dribble and PHY error.
//  Reports one end-of-frame status strobe per accepted frame to the RX buffer / APB status logic.
// PARAMETERS
//  MIN_PRE    7     minimum 0x5 preamble nibbles before SFD nibble 0xD (fewer -> frame dropped)
//  MIN_FRAME  64    minimum frame bytes, DA..FCS inclusive; shorter -> rx_short_o
//  MAX_FRAME  1518  maximum frame bytes, DA..FCS inclusive; longer -> rx_long_o
// PORTS
//  MRxClk        in   1   receive clock; sole clock, all logic on rising edge
//  prst_i        in   1   synchronous active-high reset
//  MRxDV         in   1   PHY receive data valid
//  MRxD          in   4   PHY receive nibble
//  MRxErr        in   1   PHY receive error
//  rx_data_o     out  8   assembled byte; valid only while rx_valid_o=1
//  rx_valid_o    out  1   1-cycle strobe per byte
//  rx_sof_o      out  1   high with rx_valid_o on first byte of frame
//  rx_eof_o      out  1   1-cycle end-of-frame status strobe; rx_len_o and flags valid only here
//  rx_len_o      out  16  frame byte count incl. FCS, saturates at MAX_FRAME+1
//  rx_crc_err_o  out  1   FCS residue mismatch
//  rx_short_o    out  1   rx_len_o < MIN_FRAME
//  rx_long_o     out  1   rx_len_o > MAX_FRAME
//  rx_phy_err_o  out  1   MRxErr seen during DATA
//  rx_dribble_o  out  1   odd nibble count at end; trailing nibble discarded
// BEHAVIOUR
//  Reset: all outputs 0; state WAIT_IDLE; nibble phase, counters, flags cleared; CRC reg = 32'hFFFFFFFF.
//  Reset mid-frame: frame abandoned, no eof emitted; WAIT_IDLE holds until MRxDV=0 is sampled.
//  FSM, one transition per MRxClk:
//   WAIT_IDLE: MRxDV=0 -> IDLE.
//   IDLE: MRxDV=1 & MRxD=4'h5 -> PRE (pre_cnt=1); MRxDV=1 & other nibble -> DROP.
//   PRE: MRxDV=0 -> IDLE (silent); 4'h5 -> pre_cnt++ (saturating at 15);
//        4'hD & pre_cnt>=MIN_PRE -> DATA; 4'hD & pre_cnt<MIN_PRE, or any other nibble -> DROP.
//   DATA: MRxDV=1 -> take nibble; even phase stores low nibble, odd phase completes {MRxD,low}.
//         MRxDV=0 -> IDLE, rx_eof_o asserted in the following cycle.
//   DROP: no output; MRxDV=0 -> IDLE; never emits rx_eof_o.
//  Byte output: registered; rx_valid_o=1 the cycle after the high nibble is sampled; the first byte
//   of a frame also has rx_sof_o=1. Byte cadence is one strobe per two MRxClk.
//  Length: byte counter increments per completed byte and saturates at MAX_FRAME+1. Once MAX_FRAME+1
//   is reached, further bytes are not output (no rx_valid_o), but DATA continues until MRxDV=0.
//  CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, LSB first, over every completed byte
//   including FCS. crc_err = (reg != 32'hDEBB20E3) at end. Updated per byte, or per nibble (equivalent).
//  MRxErr: sampled every DATA cycle with MRxDV=1; sticky until eof.
//  Dribble: MRxDV falls with an odd nibble stored -> rx_dribble_o=1; nibble not output, not in CRC.
//  EOF cycle: rx_len_o and all flags presented with rx_eof_o, held stable until the next eof.
//   Internal counter, CRC and flags reinit in the same edge.
//  Back-to-back: MRxDV=0 for a single cycle is a valid IFG; the eof cycle may coincide with the IDLE->PRE
//   transition of the next frame, and both must be handled correctly.
//  Empty frame: SFD followed directly by MRxDV=0 -> eof with len=0, short=1, crc_err=1.
//  rx_valid_o and rx_eof_o are never both high: eof follows the last byte by >=1 cycle.
// TESTING
//  1. 7x5,D, 64-byte frame with good FCS -> 64 valid strobes, sof on byte0, eof len=64, all flags 0.
//  2. Same frame with FCS byte 63 XOR 0x01 -> eof len=64, crc_err=1, others 0.
//  3. 1519-byte good-FCS frame -> 1518 valid strobes, eof len=1519, long=1.
//     40-byte frame -> eof len=40, short=1.
//  4. MRxErr pulse at byte 20; separately, one extra nibble after FCS
//     -> phy_err=1; dribble=1 with len=64, crc_err=0.
//  5. Preamble of 3x5 then D; separately, preamble 7x5 then A -> no valid, no eof; next good frame received.
//  6. prst_i for 1 cycle at byte 30 while MRxDV stays high -> no eof, no valid until MRxDV low.
//     Two good frames with 1-cycle IFG -> two eofs, both clean.

Source files
------------

// File: rtl/eth_rx_mii_framer.sv
// ============================================================================
//  Module   : eth_rx_mii_framer
//  Purpose  : MII RX framer - preamble/SFD strip, byte assembly, FCS/length/status
//  Revision : 1.0
// ============================================================================
`default_nettype none

module eth_rx_mii_framer #(
   parameter int MIN_PRE   = 7,
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic        MRxClk,
   input  logic        prst_i,
   input  logic        MRxDV,
   input  logic [3:0]  MRxD,
   input  logic        MRxErr,
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   output logic        rx_sof_o,
   output logic        rx_eof_o,
   output logic [15:0] rx_len_o,
   output logic        rx_crc_err_o,
   output logic        rx_short_o,
   output logic        rx_long_o,
   output logic        rx_phy_err_o,
   output logic        rx_dribble_o
);

   localparam logic [15:0] c_MIN_LEN = 16'(MIN_FRAME);
   localparam logic [15:0] c_MAX_LEN = 16'(MAX_FRAME);
   localparam logic [15:0] c_SAT_LEN = 16'(MAX_FRAME + 1);
   localparam logic [3:0]  c_MIN_PRE = 4'(MIN_PRE);
   localparam logic [31:0] c_POLY    = 32'hEDB88320;
   localparam logic [31:0] c_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      S_WAIT_IDLE = 3'd0,
      S_IDLE      = 3'd1,
      S_PRE       = 3'd2,
      S_DATA      = 3'd3,
      S_DROP      = 3'd4
   } state_t;

   state_t      r_state;
   logic [3:0]  r_pre_cnt;
   logic        r_phase;
   logic [3:0]  r_low;
   logic [15:0] r_byte_cnt;
   logic [31:0] r_crc;
   logic        r_phy_err;
   logic        r_first;

   logic [7:0]  w_byte;
   logic [31:0] w_crc_next;

   function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ c_POLY) : (c >> 1);
      return c;
   endfunction

   assign w_byte     = {MRxD, r_low};
   assign w_crc_next = f_crc_byte(r_crc, w_byte);

   always_ff @(posedge MRxClk) begin
      if (prst_i) begin
         r_state      <= S_WAIT_IDLE;
         r_pre_cnt    <= 4'd0;
         r_phase      <= 1'b0;
         r_low        <= 4'd0;
         r_byte_cnt   <= 16'd0;
         r_crc        <= 32'hFFFFFFFF;
         r_phy_err    <= 1'b0;
         r_first      <= 1'b0;
         rx_data_o    <= 8'd0;
         rx_valid_o   <= 1'b0;
         rx_sof_o     <= 1'b0;
         rx_eof_o     <= 1'b0;
         rx_len_o     <= 16'd0;
         rx_crc_err_o <= 1'b0;
         rx_short_o   <= 1'b0;
         rx_long_o    <= 1'b0;
         rx_phy_err_o <= 1'b0;
         rx_dribble_o <= 1'b0;
      end else begin
         rx_valid_o <= 1'b0;
         rx_sof_o   <= 1'b0;
         rx_eof_o   <= 1'b0;
         case (r_state)
            S_WAIT_IDLE: if (!MRxDV) r_state <= S_IDLE;
            S_IDLE: begin
               if (MRxDV) begin
                  if (MRxD == 4'h5) begin
                     r_state   <= S_PRE;
                     r_pre_cnt <= 4'd1;
                  end else begin
                     r_state <= S_DROP;
                  end
               end
            end
            S_PRE: begin
               if (!MRxDV) begin
                  r_state <= S_IDLE;
               end else if (MRxD == 4'h5) begin
                  if (r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
               end else if (MRxD == 4'hD && r_pre_cnt >= c_MIN_PRE) begin
                  r_state <= S_DATA;
                  r_first <= 1'b1;
               end else begin
                  r_state <= S_DROP;
               end
            end
            S_DATA: begin
               if (MRxDV) begin
                  if (MRxErr) r_phy_err <= 1'b1;
                  if (!r_phase) begin
                     r_low   <= MRxD;
                     r_phase <= 1'b1;
                  end else begin
                     r_phase <= 1'b0;
                     r_crc   <= w_crc_next;
                     if (r_byte_cnt != c_SAT_LEN) r_byte_cnt <= r_byte_cnt + 16'd1;
                     // Bytes past MAX_FRAME still feed the CRC but are not streamed
                     if (r_byte_cnt < c_MAX_LEN) begin
                        rx_valid_o <= 1'b1;
                        rx_data_o  <= w_byte;
                        rx_sof_o   <= r_first;
                        r_first    <= 1'b0;
                     end
                  end
               end else begin
                  r_state      <= S_IDLE;
                  rx_eof_o     <= 1'b1;
                  rx_len_o     <= r_byte_cnt;
                  rx_crc_err_o <= (r_crc != c_RESIDUE);
                  rx_short_o   <= (r_byte_cnt < c_MIN_LEN);
                  rx_long_o    <= (r_byte_cnt > c_MAX_LEN);
                  rx_phy_err_o <= r_phy_err;
                  rx_dribble_o <= r_phase;
                  r_byte_cnt   <= 16'd0;
                  r_crc        <= 32'hFFFFFFFF;
                  r_phy_err    <= 1'b0;
                  r_phase      <= 1'b0;
                  r_first      <= 1'b0;
               end
            end
            S_DROP: if (!MRxDV) r_state <= S_IDLE;
            default: r_state <= S_WAIT_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
